// File: rtl/fifo_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_pkg
// Brief    : Shared types and helpers for the FIFO-fed UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Even parity of a data byte (1 when the byte has an odd number of ones).
    function automatic logic byte_parity(input logic [DATA_W-1:0] b);
        return ^b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx_if
// Brief    : FIFO read-side handshake between the byte FIFO and the UART TX.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_uart_tx_if;
    import fifo_uart_pkg::*;

    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_get;

    // master: the consumer that pops; slave: the FIFO that supplies data.
    modport master (input fifo_empty, input fifo_data, output fifo_get);
    modport slave  (output fifo_empty, output fifo_data, input fifo_get);

endinterface
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_bit_timer
// Brief    : Per-bit down-counter; reloads CLKS_PER_BIT-1, ticks at zero.
// Revision : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  i_load,
    output logic o_tick
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] C_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= C_RELOAD;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tick = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Brief    : Pops bytes from a FIFO and serialises them as 8N1 / 8x1 frames.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  wire                   clk,
    input  wire                   rst_n,
    input  wire                   i_enable,
    fifo_uart_tx_if.master        fifo_if,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_byte_done
);

    tx_state_t         r_state;
    tx_state_t         w_state_next;
    logic [DATA_W-1:0] r_shreg;
    logic [2:0]        r_bit_idx;
    logic              r_parity;
    logic              r_tx;
    logic              w_tick;
    logic              w_load;
    logic              w_get;
    logic              w_shift;
    logic              w_tx_next;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // tx is registered, so the line level for the next cycle is decided here.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_get        = 1'b0;
        w_shift      = 1'b0;
        w_tx_next    = r_tx;
        case (r_state)
            IDLE: begin
                if (rst_n && i_enable && !fifo_if.fifo_empty) begin
                    w_get        = 1'b1;
                    w_load       = 1'b1;
                    w_tx_next    = 1'b0;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_tick) begin
                    w_load       = 1'b1;
                    w_tx_next    = r_shreg[0];
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_load  = 1'b1;
                    w_shift = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_tx_next    = PARITY_EN ? r_parity : 1'b1;
                        w_state_next = PARITY_EN ? PARITY : STOP;
                    end else begin
                        w_tx_next = r_shreg[1];
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_load       = 1'b1;
                    w_tx_next    = 1'b1;
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_tx_next    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_tx_next    = 1'b1;
                w_state_next = IDLE;
            end
        endcase
    end

    // Parity is taken from the byte as popped, before any shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg   <= '0;
            r_bit_idx <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_tx <= w_tx_next;
            if (w_get) begin
                r_shreg   <= fifo_if.fifo_data;
                r_bit_idx <= '0;
                r_parity  <= byte_parity(fifo_if.fifo_data) ^ PARITY_ODD;
            end else if (w_shift) begin
                r_shreg   <= r_shreg >> 1;
                r_bit_idx <= r_bit_idx + 1'b1;
            end
        end
    end

    assign fifo_if.fifo_get = w_get;
    assign o_tx             = r_tx;
    assign o_busy           = (r_state != IDLE);
    assign o_byte_done      = (r_state == STOP) && w_tick;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Brief    : Self-checking bench: three DUTs (no parity, even, odd) at C=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;
    import fifo_uart_pkg::*;

    localparam int C = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en [3];
    logic tx_w [3];
    logic busy_w [3];
    logic done_w [3];

    fifo_uart_tx_if if0 ();
    fifo_uart_tx_if if1 ();
    fifo_uart_tx_if if2 ();

    fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_enable(en[0]), .fifo_if(if0),
        .o_tx(tx_w[0]), .o_busy(busy_w[0]), .o_byte_done(done_w[0]));
    fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_enable(en[1]), .fifo_if(if1),
        .o_tx(tx_w[1]), .o_busy(busy_w[1]), .o_byte_done(done_w[1]));
    fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .i_enable(en[2]), .fifo_if(if2),
        .o_tx(tx_w[2]), .o_busy(busy_w[2]), .o_byte_done(done_w[2]));

    always #5 clk = ~clk;

    // FIFO contents per DUT, and the reference model's frame tracker.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    bit         m_active [3];
    int         m_age [3];
    logic [7:0] m_byte [3];
    logic [3:0] s_vec [3];  // {get, busy, byte_done, tx}
    logic [3:0] e_vec [3];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    function automatic int qsize(int k);
        if (k == 0) return q0.size();
        if (k == 1) return q1.size();
        return q2.size();
    endfunction

    function automatic logic [7:0] qfront(int k);
        if (k == 0) return (q0.size() != 0) ? q0[0] : 8'h00;
        if (k == 1) return (q1.size() != 0) ? q1[0] : 8'h00;
        return (q2.size() != 0) ? q2[0] : 8'h00;
    endfunction

    function automatic int flen(int k);
        return (k == 0) ? 10 * C : 11 * C;
    endfunction

    // Line level a cycles after the pop: start, 8 data LSB first, [parity], stop.
    function automatic logic exp_tx(logic [7:0] b, bit pe, bit po, int a);
        int n;
        n = (a - 1) / C;
        if (n == 0) return 1'b0;
        if (n <= 8) return b[n-1];
        if (pe && n == 9) return (^b) ^ po;
        return 1'b1;
    endfunction

    task automatic drive_all();
        if0.fifo_empty = (q0.size() == 0);
        if0.fifo_data  = qfront(0);
        if1.fifo_empty = (q1.size() == 0);
        if1.fifo_data  = qfront(1);
        if2.fifo_empty = (q2.size() == 0);
        if2.fifo_data  = qfront(2);
    endtask

    task automatic push(int k, logic [7:0] b);
        if (k == 0) q0.push_back(b);
        else if (k == 1) q1.push_back(b);
        else q2.push_back(b);
        drive_all();
    endtask

    task automatic tick_cycle();
        logic pend [3];
        #1;
        pend[0] = if0.fifo_get;
        pend[1] = if1.fifo_get;
        pend[2] = if2.fifo_get;
        for (int k = 0; k < 3; k++) begin
            if (rst_n && en[k] && qsize(k) != 0 && !m_active[k]) begin
                m_active[k] = 1'b1;
                m_age[k]    = 0;
                m_byte[k]   = qfront(k);
            end
        end
        @(posedge clk);
        #1;
        if (pend[0]) void'(q0.pop_front());
        if (pend[1]) void'(q1.pop_front());
        if (pend[2]) void'(q2.pop_front());
        drive_all();
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) m_active[k] = 1'b0;
            else if (m_active[k]) begin
                m_age[k] = m_age[k] + 1;
                if (m_age[k] > flen(k)) m_active[k] = 1'b0;
            end
        end
        #1;
        s_vec[0] = {if0.fifo_get, busy_w[0], done_w[0], tx_w[0]};
        s_vec[1] = {if1.fifo_get, busy_w[1], done_w[1], tx_w[1]};
        s_vec[2] = {if2.fifo_get, busy_w[2], done_w[2], tx_w[2]};
        for (int k = 0; k < 3; k++) begin
            e_vec[k] = {rst_n && en[k] && qsize(k) != 0 && !m_active[k],
                        m_active[k],
                        m_active[k] && m_age[k] == flen(k),
                        m_active[k] ? exp_tx(m_byte[k], k != 0, k == 2, m_age[k]) : 1'b1};
        end
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        push(0, 8'($urandom));
        for (int i = 0; i < 6; i++) begin
            tick_cycle();
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (s_vec[k] !== e_vec[k])
                    $display("FAIL reset_hold dut%0d cyc=%0d got{get,busy,done,tx}=%b exp=%b", k, cyc, s_vec[k], e_vec[k]);
                else n_pass++;
            end
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (if0.fifo_get !== 1'b1) $display("FAIL reset_release_pop got=%b exp=1", if0.fifo_get);
        else n_pass++;
        for (int i = 0; i < 45; i++) begin
            tick_cycle();
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (s_vec[k] !== e_vec[k])
                    $display("FAIL reset_frame dut%0d cyc=%0d got{get,busy,done,tx}=%b exp=%b", k, cyc, s_vec[k], e_vec[k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_single_byte();
        logic [9:0] pat;
        pat = 10'b1101001010;
        push(0, 8'hA5);
        #1;
        n_checks++;
        if (if0.fifo_get !== 1'b1) $display("FAIL single_pop got=%b exp=1", if0.fifo_get);
        else n_pass++;
        for (int a = 1; a <= 41; a++) begin
            tick_cycle();
            n_checks++;
            if (s_vec[0] !== e_vec[0])
                $display("FAIL single_model a=%0d got{get,busy,done,tx}=%b exp=%b", a, s_vec[0], e_vec[0]);
            else n_pass++;
            if ((a - 1) % C == 0 && a <= 37) begin
                n_checks++;
                if (s_vec[0][0] !== pat[(a-1)/C]) $display("FAIL single_tx a=%0d got=%b exp=%b", a, s_vec[0][0], pat[(a-1)/C]);
                else n_pass++;
            end
            if (a == 40) begin
                n_checks++;
                if (s_vec[0][1] !== 1'b1) $display("FAIL single_done got=%b exp=1", s_vec[0][1]);
                else n_pass++;
            end
            if (a == 41) begin
                n_checks++;
                if (s_vec[0][2] !== 1'b0) $display("FAIL single_busy_low got=%b exp=0", s_vec[0][2]);
                else n_pass++;
            end
        end
        for (int i = 0; i < 3; i++) tick_cycle();
    endtask

    task automatic test_back_to_back();
        int pops;
        int tp;
        pops = 0;
        tp = -1;
        push(0, 8'h00);
        push(0, 8'hFF);
        #1;
        n_checks++;
        if (if0.fifo_get !== 1'b1) $display("FAIL b2b_first_pop got=%b exp=1", if0.fifo_get);
        else n_pass++;
        for (int a = 1; a <= 90; a++) begin
            tick_cycle();
            n_checks++;
            if (s_vec[0] !== e_vec[0])
                $display("FAIL b2b_model a=%0d got{get,busy,done,tx}=%b exp=%b", a, s_vec[0], e_vec[0]);
            else n_pass++;
            if (s_vec[0][3]) begin
                pops++;
                tp = a;
            end
            if (a >= 42 && a <= 78 && (a - 42) % C == 0) begin
                n_checks++;
                if (s_vec[0][0] !== ((a - 42) / C != 0))
                    $display("FAIL b2b_second_tx a=%0d got=%b exp=%b", a, s_vec[0][0], ((a - 42) / C != 0));
                else n_pass++;
            end
        end
        n_checks++;
        if (pops != 1 || tp != 41) $display("FAIL b2b_spacing got pops=%0d at=%0d exp pops=1 at=41", pops, tp);
        else n_pass++;
    endtask

    task automatic test_empty_idle();
        for (int i = 0; i < 200; i++) begin
            tick_cycle();
            n_checks++;
            if (s_vec[0] !== e_vec[0] || s_vec[0] !== 4'b0001)
                $display("FAIL empty_idle cyc=%0d got{get,busy,done,tx}=%b exp=0001", cyc, s_vec[0]);
            else n_pass++;
        end
        push(0, 8'h3C);
        #1;
        n_checks++;
        if (if0.fifo_get !== 1'b1) $display("FAIL empty_then_push_pop got=%b exp=1", if0.fifo_get);
        else n_pass++;
        for (int i = 0; i < 45; i++) begin
            tick_cycle();
            n_checks++;
            if (s_vec[0] !== e_vec[0])
                $display("FAIL empty_push_frame cyc=%0d got{get,busy,done,tx}=%b exp=%b", cyc, s_vec[0], e_vec[0]);
            else n_pass++;
        end
    endtask

    task automatic test_enable_drop();
        int pops;
        pops = 0;
        push(0, 8'h5A);
        push(0, 8'hC3);
        #1;
        n_checks++;
        if (if0.fifo_get !== 1'b1) $display("FAIL endrop_pop got=%b exp=1", if0.fifo_get);
        else n_pass++;
        for (int a = 1; a <= 60; a++) begin
            tick_cycle();
            if (a == 10) en[0] = 1'b0;
            n_checks++;
            if (s_vec[0] !== e_vec[0])
                $display("FAIL endrop_model a=%0d got{get,busy,done,tx}=%b exp=%b", a, s_vec[0], e_vec[0]);
            else n_pass++;
            if (s_vec[0][3]) pops++;
            if (a == 40) begin
                n_checks++;
                if (s_vec[0][1] !== 1'b1) $display("FAIL endrop_done got=%b exp=1", s_vec[0][1]);
                else n_pass++;
            end
        end
        n_checks++;
        if (pops != 0) $display("FAIL endrop_no_pop got=%0d exp=0", pops);
        else n_pass++;
        en[0] = 1'b1;
        #1;
        n_checks++;
        if (if0.fifo_get !== 1'b1) $display("FAIL endrop_resume got=%b exp=1", if0.fifo_get);
        else n_pass++;
        for (int i = 0; i < 45; i++) begin
            tick_cycle();
            n_checks++;
            if (s_vec[0] !== e_vec[0])
                $display("FAIL endrop_resume_frame cyc=%0d got{get,busy,done,tx}=%b exp=%b", cyc, s_vec[0], e_vec[0]);
            else n_pass++;
        end
    endtask

    task automatic test_parity();
        push(1, 8'h07);
        push(2, 8'h07);
        #1;
        n_checks++;
        if (if1.fifo_get !== 1'b1 || if2.fifo_get !== 1'b1)
            $display("FAIL parity_pop got=%b%b exp=11", if1.fifo_get, if2.fifo_get);
        else n_pass++;
        for (int a = 1; a <= 46; a++) begin
            tick_cycle();
            for (int k = 1; k < 3; k++) begin
                n_checks++;
                if (s_vec[k] !== e_vec[k])
                    $display("FAIL parity_model dut%0d a=%0d got{get,busy,done,tx}=%b exp=%b", k, a, s_vec[k], e_vec[k]);
                else n_pass++;
            end
            if (a == 37) begin
                n_checks++;
                if (s_vec[1][0] !== 1'b1 || s_vec[2][0] !== 1'b0)
                    $display("FAIL parity_bit got even=%b odd=%b exp even=1 odd=0", s_vec[1][0], s_vec[2][0]);
                else n_pass++;
            end
            if (a == 44) begin
                n_checks++;
                if (s_vec[1][1] !== 1'b1 || s_vec[2][1] !== 1'b1)
                    $display("FAIL parity_len got done=%b%b exp=11", s_vec[1][1], s_vec[2][1]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        push(0, 8'($urandom));
        #1;
        n_checks++;
        if (if0.fifo_get !== 1'b1) $display("FAIL rstmid_pop got=%b exp=1", if0.fifo_get);
        else n_pass++;
        for (int a = 1; a <= 15; a++) tick_cycle();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0)
            $display("FAIL rstmid_async got tx=%b busy=%b exp tx=1 busy=0", tx_w[0], busy_w[0]);
        else n_pass++;
        for (int i = 0; i < 3; i++) tick_cycle();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (if0.fifo_get !== 1'b0) $display("FAIL rstmid_no_repop got=%b exp=0", if0.fifo_get);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            tick_cycle();
            n_checks++;
            if (s_vec[0] !== e_vec[0])
                $display("FAIL rstmid_idle cyc=%0d got{get,busy,done,tx}=%b exp=%b", cyc, s_vec[0], e_vec[0]);
            else n_pass++;
        end
        push(0, 8'($urandom));
        for (int i = 0; i < 45; i++) begin
            tick_cycle();
            n_checks++;
            if (s_vec[0] !== e_vec[0])
                $display("FAIL rstmid_after cyc=%0d got{get,busy,done,tx}=%b exp=%b", cyc, s_vec[0], e_vec[0]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 850; i++) begin
            if (i < 600) begin
                if ($urandom_range(15) == 0 && q0.size() < 3) push(0, 8'($urandom));
                if ($urandom_range(39) == 0 && q1.size() < 3) push(1, 8'($urandom));
                if ($urandom_range(39) == 0 && q2.size() < 3) push(2, 8'($urandom));
                if ($urandom_range(31) == 0) en[0] = ~en[0];
            end else begin
                en[0] = 1'b1;
            end
            tick_cycle();
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (s_vec[k] !== e_vec[k])
                    $display("FAIL random dut%0d cyc=%0d got{get,busy,done,tx}=%b exp=%b", k, cyc, s_vec[k], e_vec[k]);
                else n_pass++;
            end
        end
        n_checks++;
        if (q0.size() != 0) $display("FAIL random_drain got=%0d exp=0", q0.size());
        else n_pass++;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            en[k]       = 1'b1;
            m_active[k] = 1'b0;
            m_age[k]    = 0;
            m_byte[k]   = 8'h00;
        end
        drive_all();
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_empty_idle();
        test_enable_drop();
        test_parity();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
